// File: rtl/nco_multi_if.sv
// ---------------------------------------------------------------------------
// nco_multi_if
//
// Bundles the register write port, the commit/clear controls and the
// waveform outputs of the multi-channel NCO into one interface so the
// oscillator and whatever drives it share a single connection.
//
// Signals:
//   wr_en      write strobe, one byte write per cycle while high
//   wr_chan    target channel of the write
//   wr_reg     register select: 0-3 tuning-word bytes (little-endian),
//              4 control register, 5-7 reserved
//   wr_data    write data byte
//   commit     copies every channel's shadow settings into its active copy
//   phase_clr  per-channel accumulator clear
//   wave_out   registered 8-bit sample per channel, channel c in [8c+7:8c]
//   wrap       registered one-cycle overflow pulse per channel
//
// Modports:
//   master  drives the write port and controls, observes the outputs
//   slave   the oscillator side
// ---------------------------------------------------------------------------
interface nco_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);

    logic                    wr_en;
    logic [CHAN_W-1:0]       wr_chan;
    logic [2:0]              wr_reg;
    logic [7:0]              wr_data;
    logic                    commit;
    logic [CHANNELS-1:0]     phase_clr;
    logic [8*CHANNELS-1:0]   wave_out;
    logic [CHANNELS-1:0]     wrap;

    modport master (
        output wr_en,
        output wr_chan,
        output wr_reg,
        output wr_data,
        output commit,
        output phase_clr,
        input  wave_out,
        input  wrap
    );

    modport slave (
        input  wr_en,
        input  wr_chan,
        input  wr_reg,
        input  wr_data,
        input  commit,
        input  phase_clr,
        output wave_out,
        output wrap
    );

endinterface

// File: rtl/nco_multi.sv
// ---------------------------------------------------------------------------
// nco_multi
//
// Multi-channel numerically controlled oscillator. Every channel owns a
// phase accumulator, a double-buffered tuning word and a double-buffered
// control register (waveform mode + enable). Byte writes land in the shadow
// copies; a commit pulse moves all shadows into the active copies of every
// channel on the same edge, so retuning several channels is glitch-free
// and phase-coherent.
//
// Parameters:
//   CHANNELS  number of channels, 1..8
//   ACC_W     accumulator / tuning-word width, 16, 24 or 32
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset, clears every register
//   bus   nco_multi_if slave modport: write port, commit, phase_clr in;
//         wave_out and wrap out
//
// Pipeline:
//   edge n    : accumulator updates using the active settings held before n
//   edge n+1  : wave_out shows the sample for that accumulator value and
//               wrap shows whether the edge-n update overflowed
// ---------------------------------------------------------------------------
module nco_multi #(
    parameter int CHANNELS = 4,
    parameter int ACC_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    nco_multi_if.slave  bus
);

    localparam int FTW_BYTES = ACC_W / 8;

    typedef enum logic [1:0] {
        MODE_SQUARE   = 2'd0,
        MODE_SAWTOOTH = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_MUTE     = 2'd3
    } waveMode_t;

    // Only the meaningful control bits are kept; the reserved upper bits of
    // a control write have no effect anywhere, so they are not stored.
    typedef struct packed {
        logic      enable;
        waveMode_t mode;
    } ctl_t;

    logic [ACC_W-1:0]      ftwShadow_q [CHANNELS];
    logic [ACC_W-1:0]      ftwShadow_d [CHANNELS];
    ctl_t                  ctlShadow_q [CHANNELS];
    ctl_t                  ctlShadow_d [CHANNELS];
    logic [ACC_W-1:0]      ftwActive_q [CHANNELS];
    logic [ACC_W-1:0]      ftwActive_d [CHANNELS];
    ctl_t                  ctlActive_q [CHANNELS];
    ctl_t                  ctlActive_d [CHANNELS];
    logic [ACC_W-1:0]      acc_q       [CHANNELS];
    logic [ACC_W-1:0]      acc_d       [CHANNELS];
    logic [ACC_W:0]        sumFull     [CHANNELS];
    logic [CHANNELS-1:0]   carry_q;
    logic [CHANNELS-1:0]   carry_d;
    logic [CHANNELS-1:0]   wrap_q;
    logic [CHANNELS-1:0]   wrap_d;
    logic [8*CHANNELS-1:0] wave_q;
    logic [8*CHANNELS-1:0] wave_d;

    logic                  wrInRange;
    logic                  ftwWrite;
    logic                  ctlWrite;

    // Write decode. A write only counts when it targets an existing channel
    // and a register that exists at this accumulator width; everything else
    // (reserved selects, tuning bytes above ACC_W, channels past CHANNELS)
    // falls through with no state change.
    always_comb begin
        wrInRange = bus.wr_en && (int'(bus.wr_chan) < CHANNELS);
        ftwWrite  = wrInRange && (int'(bus.wr_reg) < FTW_BYTES);
        ctlWrite  = wrInRange && (bus.wr_reg == 3'd4);
    end

    // Shadow next-state. The decoded byte is merged into the addressed
    // channel's shadow tuning word, or the control shadow is replaced.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ftwShadow_d[c] = ftwShadow_q[c];
            ctlShadow_d[c] = ctlShadow_q[c];
            if (int'(bus.wr_chan) == c) begin
                if (ftwWrite) begin
                    for (int b = 0; b < FTW_BYTES; b++) begin
                        if (int'(bus.wr_reg) == b) begin
                            ftwShadow_d[c][8*b +: 8] = bus.wr_data;
                        end
                    end
                end
                if (ctlWrite) begin
                    ctlShadow_d[c] = ctl_t'(bus.wr_data[2:0]);
                end
            end
        end
    end

    // Active next-state. Commit copies from the shadow next-state rather
    // than the shadow register so a write landing on the commit edge is
    // included in that commit.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ftwActive_d[c] = ftwActive_q[c];
            ctlActive_d[c] = ctlActive_q[c];
            if (bus.commit) begin
                ftwActive_d[c] = ftwShadow_d[c];
                ctlActive_d[c] = ctlShadow_d[c];
            end
        end
    end

    // Accumulator next-state. The add uses the active settings held before
    // this edge, so a commit only influences the accumulator from the edge
    // after it. The extra top bit of the sum is the overflow carry, which is
    // held one stage so the wrap pulse lines up with the first sample taken
    // after the overflow. A clear zeroes the accumulator and drops any
    // carry so no wrap is reported for a cleared channel.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sumFull[c] = {1'b0, acc_q[c]} + {1'b0, ftwActive_q[c]};
            acc_d[c]   = acc_q[c];
            carry_d[c] = 1'b0;
            if (bus.phase_clr[c]) begin
                acc_d[c]   = '0;
                carry_d[c] = 1'b0;
            end else if (ctlActive_q[c].enable) begin
                acc_d[c]   = sumFull[c][ACC_W-1:0];
                carry_d[c] = sumFull[c][ACC_W];
            end
        end
    end

    // Waveform shaping from the current accumulator and active mode. The
    // triangle folds the byte just below the MSB: rising on the first half
    // of the cycle, mirrored on the second half, giving a peak of 0xFF right
    // after the midpoint. Mute only silences the output; the accumulator
    // keeps advancing so phase is preserved across mute.
    always_comb begin
        wave_d = '0;
        wrap_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (ctlActive_q[c].mode)
                MODE_SQUARE:
                    wave_d[8*c +: 8] = {8{acc_q[c][ACC_W-1]}};
                MODE_SAWTOOTH:
                    wave_d[8*c +: 8] = acc_q[c][ACC_W-1 -: 8];
                MODE_TRIANGLE:
                    wave_d[8*c +: 8] = acc_q[c][ACC_W-1]
                                       ? ~acc_q[c][ACC_W-2 -: 8]
                                       :  acc_q[c][ACC_W-2 -: 8];
                default:
                    wave_d[8*c +: 8] = 8'h00;
            endcase
            wrap_d[c] = carry_q[c] & ~bus.phase_clr[c];
        end
    end

    // State registers. Reset discards everything, including uncommitted
    // shadow settings, so the block always restarts from a known state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ftwShadow_q[c] <= '0;
                ctlShadow_q[c] <= '0;
                ftwActive_q[c] <= '0;
                ctlActive_q[c] <= '0;
                acc_q[c]       <= '0;
            end
            carry_q <= '0;
            wrap_q  <= '0;
            wave_q  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                ftwShadow_q[c] <= ftwShadow_d[c];
                ctlShadow_q[c] <= ctlShadow_d[c];
                ftwActive_q[c] <= ftwActive_d[c];
                ctlActive_q[c] <= ctlActive_d[c];
                acc_q[c]       <= acc_d[c];
            end
            carry_q <= carry_d;
            wrap_q  <= wrap_d;
            wave_q  <= wave_d;
        end
    end

    assign bus.wave_out = wave_q;
    assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_nco_multi.sv
// ---------------------------------------------------------------------------
// tb_nco_multi
//
// Directed bench for nco_multi (CHANNELS=4, ACC_W=16). The stimulus process
// drives the write port and, for each scenario, queues the samples it
// expects on specific cycles. A monitor on the falling edge picks up every
// queued entry due on the current cycle and compares it with the outputs.
// ---------------------------------------------------------------------------
module tb_nco_multi;

    localparam int CHANNELS = 4;
    localparam int ACC_W    = 16;

    typedef struct {
        int         cyc;
        int         ch;
        logic [7:0] wave;
        logic       wrapBit;
        bit         wrapCare;
        string      name;
    } sbEntry_t;

    logic clk = 1'b0;
    logic rst;

    sbEntry_t sb[$];
    int       cycleCount = 0;
    int       total = 0;
    int       bad = 0;

    logic [7:0] sawTab  [4]  = '{8'h00, 8'h40, 8'h80, 8'hC0};
    logic [7:0] halfTab [8]  = '{8'h00, 8'h20, 8'h40, 8'h60,
                                 8'h80, 8'hA0, 8'hC0, 8'hE0};
    logic [7:0] triTab  [16] = '{8'h00, 8'h20, 8'h40, 8'h60,
                                 8'h80, 8'hA0, 8'hC0, 8'hE0,
                                 8'hFF, 8'hDF, 8'hBF, 8'h9F,
                                 8'h7F, 8'h5F, 8'h3F, 8'h1F};

    nco_multi_if #(.CHANNELS(CHANNELS)) dutIf();

    nco_multi #(
        .CHANNELS (CHANNELS),
        .ACC_W    (ACC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dutIf.slave)
    );

    // Free-running clock and an edge counter that gives every expectation
    // an absolute cycle to land on.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Compare one due entry against the live outputs.
    task automatic checkOutput(input sbEntry_t e);
        logic [7:0] gotWave;
        logic       gotWrap;
        gotWave = dutIf.wave_out[8*e.ch +: 8];
        gotWrap = dutIf.wrap[e.ch];
        total++;
        if (gotWave !== e.wave || (e.wrapCare && gotWrap !== e.wrapBit)) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d ch%0d: got wave=%02h wrap=%b, want wave=%02h wrap=%b%s",
                     e.name, e.cyc, e.ch, gotWave, gotWrap, e.wave, e.wrapBit,
                     e.wrapCare ? "" : " (wrap not checked)");
        end
    endtask

    // Monitor: on each falling edge consume every entry due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cycleCount) begin
                checkOutput(sb[i]);
                sb.delete(i);
            end else if (sb[i].cyc < cycleCount) begin
                total++;
                bad++;
                $display("[TB] FAIL %s missed: cyc=%0d ch%0d never checked",
                         sb[i].name, sb[i].cyc, sb[i].ch);
                sb.delete(i);
            end
        end
    end

    task automatic pushExpect(input int cyc, input int ch, input logic [7:0] wave,
                              input logic wrapBit, input bit wrapCare,
                              input string name);
        sbEntry_t e;
        e.cyc      = cyc;
        e.ch       = ch;
        e.wave     = wave;
        e.wrapBit  = wrapBit;
        e.wrapCare = wrapCare;
        e.name     = name;
        sb.push_back(e);
    endtask

    task automatic pushZeros(input int fromCyc, input int toCyc,
                             input logic [3:0] chMask, input string name);
        for (int cy = fromCyc; cy <= toCyc; cy++) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (chMask[ch]) pushExpect(cy, ch, 8'h00, 1'b0, 1'b1, name);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        dutIf.wr_en     = 1'b0;
        dutIf.wr_chan   = '0;
        dutIf.wr_reg    = '0;
        dutIf.wr_data   = '0;
        dutIf.commit    = 1'b0;
        dutIf.phase_clr = '0;
    endtask

    // Drive one cycle of inputs; they are sampled on the next rising edge,
    // after which the port returns to idle.
    task automatic applyStimulus(input logic we, input int ch, input int r,
                                 input logic [7:0] d, input logic cm,
                                 input logic [3:0] clr);
        dutIf.wr_en     = we;
        dutIf.wr_chan   = 2'(ch);
        dutIf.wr_reg    = 3'(r);
        dutIf.wr_data   = d;
        dutIf.commit    = cm;
        dutIf.phase_clr = clr;
        tick();
        idleInputs();
    endtask

    task automatic waitUntil(input int target);
        while (cycleCount < target) tick();
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        int c;
        int r;
        int t0;
        int e;
        int rz;

        // Reset with random traffic on the port, then release quietly.
        rst = 1'b1;
        idleInputs();
        pushZeros(1, 5, 4'hF, "reset");
        for (int k = 0; k < 2; k++) begin
            dutIf.wr_en     = 1'b1;
            dutIf.wr_chan   = 2'($urandom_range(0, 3));
            dutIf.wr_reg    = 3'($urandom_range(0, 7));
            dutIf.wr_data   = 8'($urandom);
            dutIf.commit    = 1'($urandom_range(0, 1));
            dutIf.phase_clr = 4'($urandom);
            tick();
        end
        idleInputs();
        rst = 1'b0;
        waitUntil(5);

        // Sawtooth on ch0 at 0x4000; shadow writes must not leak before commit.
        applyStimulus(1'b1, 0, 0, 8'h00, 1'b0, 4'h0);
        applyStimulus(1'b1, 0, 1, 8'h40, 1'b0, 4'h0);
        applyStimulus(1'b1, 0, 4, 8'h05, 1'b0, 4'h0);
        pushZeros(cycleCount + 1, cycleCount + 3, 4'hF, "shadow-only");
        waitUntil(cycleCount + 2);
        applyStimulus(1'b0, 0, 0, 8'h00, 1'b1, 4'h0);
        e0 = cycleCount;
        for (int j = 1; j <= 8; j++) begin
            pushExpect(e0 + j, 0, sawTab[(j - 1) % 4], (j == 5), 1'b1, "saw");
        end
        pushZeros(e0 + 1, e0 + 8, 4'hE, "saw-others");

        // Double buffering: new tuning word waits for the next commit.
        applyStimulus(1'b1, 0, 1, 8'h20, 1'b0, 4'h0);
        waitUntil(e0 + 7);
        applyStimulus(1'b0, 0, 0, 8'h00, 1'b1, 4'h0);
        c = cycleCount;
        for (int i = 0; i <= 16; i++) begin
            pushExpect(c + 1 + i, 0, halfTab[i % 8], (i % 8 == 0), 1'b1, "dbuf");
        end
        waitUntil(c + 17);
        resetPulse();
        r = cycleCount;
        pushZeros(r, r + 2, 4'hF, "reset-mid");

        // Triangle on ch1 at 0x1000.
        waitUntil(r + 2);
        applyStimulus(1'b1, 1, 0, 8'h00, 1'b0, 4'h0);
        applyStimulus(1'b1, 1, 1, 8'h10, 1'b0, 4'h0);
        applyStimulus(1'b1, 1, 4, 8'h06, 1'b0, 4'h0);
        applyStimulus(1'b0, 0, 0, 8'h00, 1'b1, 4'h0);
        t0 = cycleCount;
        for (int k = 0; k < 32; k++) begin
            pushExpect(t0 + 1 + k, 1, triTab[k % 16], (k > 0 && k % 16 == 0), 1'b1, "tri");
        end
        pushZeros(t0 + 1, t0 + 4, 4'h5, "tri-others");
        waitUntil(t0 + 4);

        // ch0 sawtooth again, with reserved and out-of-width writes that
        // must be ignored, then a clear held over the overflow edge.
        applyStimulus(1'b1, 0, 0, 8'h00, 1'b0, 4'h0);
        applyStimulus(1'b1, 0, 1, 8'h40, 1'b0, 4'h0);
        applyStimulus(1'b1, 0, 4, 8'h05, 1'b0, 4'h0);
        applyStimulus(1'b1, 0, 5, 8'h13, 1'b0, 4'h0);
        applyStimulus(1'b1, 0, 2, 8'h7F, 1'b0, 4'h0);
        applyStimulus(1'b1, 0, 7, 8'h07, 1'b0, 4'h0);
        applyStimulus(1'b0, 0, 0, 8'h00, 1'b1, 4'h0);
        e = cycleCount;
        for (int j = 1; j <= 4; j++) begin
            pushExpect(e + j, 0, sawTab[(j - 1) % 4], 1'b0, 1'b1, "pre-clr");
        end
        pushExpect(e + 5, 0, 8'h00, 1'b0, 1'b1, "clr-nowrap");
        for (int n = 0; n <= 9; n++) begin
            pushExpect(e + 6 + n, 0, sawTab[n % 4], (n > 0 && n % 4 == 0), 1'b1, "clr");
        end
        pushZeros(e + 1, e + 8, 4'h4, "clr-ch2");
        waitUntil(e + 3);
        applyStimulus(1'b0, 0, 0, 8'h00, 1'b0, 4'h1);
        applyStimulus(1'b0, 0, 0, 8'h00, 1'b0, 4'h1);

        // Mute via a control write coinciding with commit, then unmute:
        // the phase must have kept advancing while muted.
        waitUntil(e + 14);
        applyStimulus(1'b1, 0, 4, 8'h07, 1'b1, 4'h0);
        for (int n = 10; n <= 12; n++) begin
            pushExpect(e + 6 + n, 0, 8'h00, 1'b0, 1'b0, "mute");
        end
        waitUntil(e + 17);
        applyStimulus(1'b1, 0, 4, 8'h05, 1'b1, 4'h0);
        for (int n = 13; n <= 20; n++) begin
            pushExpect(e + 6 + n, 0, sawTab[n % 4], (n % 4 == 0), 1'b1, "unmute");
        end

        // Uncommitted ch2 settings are discarded by a reset mid-run.
        waitUntil(e + 26);
        applyStimulus(1'b1, 2, 1, 8'h80, 1'b0, 4'h0);
        applyStimulus(1'b1, 2, 4, 8'h05, 1'b0, 4'h0);
        pushExpect(cycleCount + 1, 2, 8'h00, 1'b0, 1'b1, "shadow-ch2");
        resetPulse();
        rz = cycleCount;
        pushZeros(rz, rz + 1, 4'hF, "reset-run");
        applyStimulus(1'b0, 0, 0, 8'h00, 1'b1, 4'h0);
        pushZeros(rz + 2, rz + 6, 4'hF, "post-reset");
        waitUntil(rz + 8);

        while (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s unchecked: cyc=%0d ch%0d", sb[0].name, sb[0].cyc, sb[0].ch);
            void'(sb.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nco_multi.md
# nco_multi

Multi-channel, parametrised numerically controlled oscillator for the micro-tile family. Each channel owns a phase accumulator, a double-buffered tuning word and a waveform mode. Channels are reconfigured through a byte-wide register write port. Shadowed settings take effect on all channels in the same cycle when `commit` is pulsed. The block sits behind the tile's pin-multiplexing wrapper, which maps its ports onto the 8-bit dedicated I/O.

## Interface
Parameters:
- `CHANNELS`, default 4: number of oscillator channels, allowed range 1–8.
- `ACC_W`, default 16: accumulator and tuning-word width, one of 16, 24 or 32.

Ports:
- `clk`  in  1: single clock; every register updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `wr_en`  in  1: write strobe; one write per cycle while high.
- `wr_chan`  in  $clog2(CHANNELS) (at least 1): target channel.
- `wr_reg`  in  3: register select. Values 0–3 are tuning-word bytes 0–3, little-endian. Value 4 is the control register. Values 5–7 are reserved.
- `wr_data`  in  8: write data.
- `commit`  in  1: copies every channel's shadow registers into its active registers.
- `phase_clr`  in  CHANNELS: per-channel accumulator clear.
- `wave_out`  out  8*CHANNELS: registered waveform sample per channel; channel c occupies bits [8c+7:8c].
- `wrap`  out  CHANNELS: registered one-cycle pulse when channel c's accumulator overflows.

## Operation
- Per channel the block holds: shadow tuning word `ftw_s`, shadow control register `ctl_s`, active copies `ftw_a` and `ctl_a`, and accumulator `acc` (all ACC_W bits wide except the control registers).
- Control register layout: [1:0] = mode (0 square, 1 sawtooth, 2 triangle, 3 mute), [2] = enable, [7:3] = reserved. Reserved bits are written but ignored.
- Write decoding:
  - `wr_reg` < ACC_W/8: the selected byte of `ftw_s` is updated.
  - `wr_reg` = 4: `ctl_s` is updated.
  - Any other `wr_reg`, or `wr_chan` ≥ CHANNELS: the write is ignored and no state changes.
- Commit:
  - `commit` = 1 copies `ftw_s` → `ftw_a` and `ctl_s` → `ctl_a` for every channel on that edge.
  - If a write coincides with `commit`, the newly written byte is included in the commit (shadow-to-active bypass).
- Accumulator update, evaluated per channel in this priority order:
  1. `rst` = 1: all registers clear.
  2. `phase_clr[c]` = 1: `acc` is set to 0, and `wrap[c]` is 0 on the following cycle.
  3. `ctl_a.enable` = 1: `acc` ← (`acc` + `ftw_a`) mod 2^ACC_W, using the `ftw_a` value held before this edge. The carry-out of this addition is registered into `wrap[c]`.
  4. Otherwise: `acc` holds and `wrap[c]` is 0.
- Waveform, registered from the current `acc` with m = acc[ACC_W-1] and s = acc[ACC_W-2 -: 8]:
  - Square: 8 copies of m.
  - Sawtooth: acc[ACC_W-1 -: 8].
  - Triangle: m ? ~s : s. This peaks at 0xFF immediately after the midpoint and has slope 2 per top-byte step.
  - Mute: 0x00. The accumulator keeps running if enabled, so the phase is preserved across muting.
- `ftw_a` = 0 with enable = 1 is legal: `acc` stays constant and `wrap` is never asserted.
- Channels are fully independent apart from sharing `commit` and the write port.

## Timing
- Reset: all `acc`, shadow and active registers go to 0, every `wave_out` byte is 0x00 and every `wrap` bit is 0, starting the cycle after `rst` is sampled high.
- Asserting `rst` mid-operation discards any pending shadow values; there is no partial-state retention.
- Write → shadow: one edge. Shadow registers have no effect on outputs until committed.
- Commit → accumulator: the first increment using the new `ftw_a` happens on the edge after the commit edge.
- Accumulator → `wave_out`/`wrap`: one register stage. The sample at cycle n reflects `acc` as it stood after edge n-1; `wrap` is aligned with the first post-overflow sample.
- `phase_clr` and `commit` in the same cycle: both take effect. `acc` = 0, and the new settings apply from the next edge.
- `phase_clr` held high: `acc` stays 0, `wave_out` shows the phase-0 value for the current mode (square 0x00, sawtooth 0x00, triangle 0x00).

## Test plan
- Reset: drive `rst` high for 2 cycles with random writes, commits and clears → every `wave_out` byte is 0x00 and `wrap` = 0; after release with no writes, outputs stay 0.
- Sawtooth: CHANNELS=4, ACC_W=16, ch0 `ftw` = 0x4000, ctl = 0x05, then commit → ch0 `wave_out` cycles 0x00, 0x40, 0x80, 0xC0, 0x00, …; `wrap[0]` pulses every 4th cycle coincident with 0x00; channels 1–3 stay 0x00.
- Double buffering: while ch0 runs at 0x4000, write `ftw_s` = 0x2000 without commit → the period stays 4 cycles; pulse `commit` → the period becomes 8 cycles starting the cycle after commit.
- Triangle: ch1 `ftw` = 0x1000, ctl = 0x06, commit → ch1 `wave_out` = 0x00, 0x20, 0x40, …, 0xE0, 0xFF, 0xDF, …, 0x1F, then repeats with period 16.
- Clear and write priority: assert `phase_clr[0]` on the cycle the accumulator would overflow → `acc` = 0, no `wrap` pulse, next sample 0x00. Write with `wr_reg` = 5 or `wr_chan` = 4 → no register changes.
- Bypass and reset mid-run: write ctl = 0x07 (mute) in the same cycle as `commit` → ch0 outputs 0x00 from the next sample, and unmuting later resumes at the advanced phase. Asserting `rst` while running → all outputs 0 the next cycle.
